volume_atten: RTL and testbench

- Digital volume control for a 24-bit audio sample stream.
- Holds an attenuation level from 0 to 7. Each output sample is the input sample logically right-shifted by that level (each level divides the amplitude by 2).
- Sits between the sample source and the audio output path, and is driven by the up/down volume inputs.
- Registered output with one cycle of latency.

---
 rtl/volume_pkg.sv | 18 +
 rtl/volume_level_ctr.sv | 37 +++
 rtl/volume_atten.sv | 47 ++++
 tb/tb_volume_atten.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/volume_pkg.sv
// Shared types and default sizes for the volume attenuator slice.
package volume_pkg;

  localparam int SAMPLE_W  = 24;
  localparam int MAX_LEVEL = 7;
  localparam int LEVEL_W   = $clog2(MAX_LEVEL + 1);

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [LEVEL_W-1:0]  level_t;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_DOWN = 2'b01,
    CMD_UP   = 2'b10,
    CMD_BOTH = 2'b11
  } level_cmd_e;

endpackage

// File: rtl/volume_level_ctr.sv
// Saturating up/down attenuation level counter; exposes next and current level.
module volume_level_ctr
  import volume_pkg::*;
#(
  parameter int max_level_p = MAX_LEVEL,
  parameter int level_w_p   = $clog2(max_level_p + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 up,
  input  logic                 down,
  output logic [level_w_p-1:0] level_n,
  output logic [level_w_p-1:0] level_q
);

  localparam logic [level_w_p-1:0] MAX_L = level_w_p'(max_level_p);

  level_cmd_e cmd;

  assign cmd = level_cmd_e'({up, down});

  // Both asserted cancels out; limits saturate rather than wrap.
  always_comb begin
    level_n = level_q;
    case (cmd)
      CMD_UP:   if (level_q < MAX_L)     level_n = level_q + 1'b1;
      CMD_DOWN: if (level_q != '0)       level_n = level_q - 1'b1;
      default:  level_n = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) level_q <= '0;
    else        level_q <= level_n;
  end

endmodule

// File: rtl/volume_atten.sv
// Digital volume control: registered logical right shift of the sample by the level.
module volume_atten
  import volume_pkg::*;
#(
  parameter int width_p     = SAMPLE_W,
  parameter int max_level_p = MAX_LEVEL
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] sound_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] sound_o
);

  localparam int LW = $clog2(max_level_p + 1);

  logic [LW-1:0] level_n;
  logic [LW-1:0] level_q;

  volume_level_ctr #(
    .max_level_p (max_level_p),
    .level_w_p   (LW)
  ) u_ctr (
    .clk     (clk_i),
    .reset   (reset_i),
    .up      (up_i),
    .down    (down_i),
    .level_n (level_n),
    .level_q (level_q)
  );

  // Log shifter keyed on the next level so a step and its sample land together.
  logic [LW:0][width_p-1:0] stage;

  assign stage[0] = sound_i;

  for (genvar s = 0; s < LW; s++) begin : g_shift
    assign stage[s+1] = level_n[s] ? (stage[s] >> (1 << s)) : stage[s];
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) sound_o <= '0;
    else          sound_o <= stage[LW];
  end

endmodule

// File: tb/tb_volume_atten.sv
// Directed self-checking bench for volume_atten.
module tb_volume_atten;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [23:0] sound_i;
  logic        up_i;
  logic        down_i;
  logic [23:0] sound_o;

  int checks = 0;
  int errors = 0;

  volume_atten dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .sound_i (sound_i),
    .up_i    (up_i),
    .down_i  (down_i),
    .sound_o (sound_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input logic u, input logic d, input logic [23:0] s);
    @(negedge clk_i);
    up_i = u; down_i = d; sound_i = s;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    reset_i = 1'b0; up_i = 1'b0; down_i = 1'b0; sound_i = 24'h000005;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (sound_o !== 24'h0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=000000", i, sound_o);
      end
    end
    @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (sound_o !== 24'h000005) begin
      errors++;
      $display("FAIL reset_release got=%h exp=000005", sound_o);
    end
  endtask

  task automatic test_step_seq;
    logic [1:0]  cmd [11] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01,
                              2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
    logic [2:0]  lvl [11] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd1,
                              3'd0, 3'd0, 3'd1, 3'd2, 3'd1};
    logic [23:0] snd [11] = '{24'd0, 24'd0, 24'd0, 24'd1, 24'd1, 24'd3,
                              24'd7, 24'd8, 24'd4, 24'd2, 24'd5};
    for (int i = 0; i < 11; i++) begin
      drive(cmd[i][1], cmd[i][0], 24'(i + 1));
      checks++;
      if (sound_o !== snd[i] || dut.u_ctr.level_q !== lvl[i]) begin
        errors++;
        $display("FAIL step_seq cyc=%0d got=%h/lvl%0d exp=%h/lvl%0d",
                 i, sound_o, dut.u_ctr.level_q, snd[i], lvl[i]);
      end
    end
  endtask

  task automatic test_upper_sat;
    // Starts at level 1 from the step sequence.
    logic [23:0] exp [10] = '{24'h3FFFFF, 24'h1FFFFF, 24'h0FFFFF, 24'h07FFFF,
                              24'h03FFFF, 24'h01FFFF, 24'h01FFFF, 24'h01FFFF,
                              24'h01FFFF, 24'h01FFFF};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 24'hFFFFFF);
      checks++;
      if (sound_o !== exp[i]) begin
        errors++;
        $display("FAIL upper_sat cyc=%0d got=%h exp=%h", i, sound_o, exp[i]);
      end
    end
    checks++;
    if (dut.u_ctr.level_q !== 3'd7) begin
      errors++;
      $display("FAIL upper_sat_level got=%0d exp=7", dut.u_ctr.level_q);
    end
  endtask

  task automatic test_lower_sat;
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 24'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 24'h800000);
      checks++;
      if (sound_o !== 24'h800000 || dut.u_ctr.level_q !== 3'd0) begin
        errors++;
        $display("FAIL lower_sat cyc=%0d got=%h/lvl%0d exp=800000/lvl0",
                 i, sound_o, dut.u_ctr.level_q);
      end
    end
  endtask

  task automatic test_both;
    logic [23:0] ramp [3] = '{24'h000040, 24'h000020, 24'h000010};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 24'h000080);
      checks++;
      if (sound_o !== ramp[i]) begin
        errors++;
        $display("FAIL both_ramp cyc=%0d got=%h exp=%h", i, sound_o, ramp[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 24'h000080);
      checks++;
      if (sound_o !== 24'h000010 || dut.u_ctr.level_q !== 3'd3) begin
        errors++;
        $display("FAIL both_hold cyc=%0d got=%h/lvl%0d exp=000010/lvl3",
                 i, sound_o, dut.u_ctr.level_q);
      end
    end
  endtask

  task automatic test_mid_reset;
    drive(1'b1, 1'b0, 24'h000080);
    drive(1'b1, 1'b0, 24'h000080);
    checks++;
    if (sound_o !== 24'h000004 || dut.u_ctr.level_q !== 3'd5) begin
      errors++;
      $display("FAIL mid_reset_pre got=%h/lvl%0d exp=000004/lvl5",
               sound_o, dut.u_ctr.level_q);
    end
    @(negedge clk_i);
    up_i = 1'b0; down_i = 1'b0; sound_i = 24'h000040;
    reset_i = 1'b0;
    #1;
    checks++;
    if (sound_o !== 24'h0 || dut.u_ctr.level_q !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset_async got=%h/lvl%0d exp=000000/lvl0",
               sound_o, dut.u_ctr.level_q);
    end
    @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (sound_o !== 24'h000040) begin
      errors++;
      $display("FAIL mid_reset_release got=%h exp=000040", sound_o);
    end
  endtask

  initial begin
    test_reset();
    test_step_seq();
    test_upper_sat();
    test_lower_sat();
    test_both();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
